keypad_frame_tx: RTL and testbench
==================================

# keypad_frame_tx

Keypad frame transmitter: accepts one parallel elevator command (operation, 3-digit user ID, 4-digit password) and serialises it into the per-floor keypad code stream that the login/controller path consumes. It is the sending end of the keypad protocol. It sits in front of a floor's `keypadF*` input, driven by a panel controller or a scripted stimulus source.

## Interface
- `HOLD`, 1: clock cycles each symbol is held on `key` (1..15).
- `GAP_CYCLES`, 2: extra idle cycles after each frame; used only with `KEYPAD_TX_GAP_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 0 LOGIN, 1 ADD_USER, 2 SELECT_USER, 3 REMOVE_USER.
- `cmd_id` in 12: three BCD digits, [11:8] sent first.
- `cmd_pw` in 16: four BCD digits, [15:12] sent first; ignored by SELECT and REMOVE.
- `key` out 4: keypad code; idle value padK = 4'b1111.
- `key_valid` out 1: high while `key` carries a frame symbol.
- `frame_done` out 1: one-cycle pulse after the last symbol.
- `cmd_err` out 1: one-cycle pulse when an accepted command has a non-BCD digit.

## Operation
- Codes: digits 0–9 = 4'b0000–4'b1001, S = 4'b1010, M = 4'b1011, K = 4'b1111.
- Frames, in `key` order:
  - LOGIN (13): S d2 d1 d0 S M S p3 p2 p1 p0 S M.
  - ADD_USER (11): S d2 d1 d0 M p3 p2 p1 p0 S M.
  - SELECT_USER (6): S d2 d1 d0 M M.
  - REMOVE_USER (6): S d2 d1 d0 S M.
- FSM states: IDLE, SEND, GAP.
  - IDLE: `cmd_ready` = 1; on accept, latch op/id/pw, index = 0, hold count = 0, go to SEND.
  - SEND: emit symbol[index] for HOLD cycles, then index++. After the last symbol's final hold cycle, go to GAP (macro defined) or IDLE.
  - GAP: drive K for GAP_CYCLES, then go to IDLE.
- Digit check on accept: only digits the op uses are checked. Any digit > 9 means no transmission, `cmd_err` pulses in the next cycle, state stays IDLE.
- Inputs are sampled only at acceptance. Changes to `cmd_*` during SEND are ignored.
- `cmd_ready` = (state == IDLE) & ~rst. It is low throughout SEND and GAP.
- Index counter is 4 bits, compared against the op's frame length minus 1. It never wraps past the frame end.

## Timing
- Reset (any state, including mid-frame) values: `key` = K, `key_valid` = 0, `frame_done` = 0, `cmd_err` = 0, state IDLE.
  - Effective at the next edge.
  - An aborted frame gives no `frame_done`.
- All outputs except `cmd_ready` are registered.
- Accept at edge N: S appears on `key` with `key_valid` = 1 from edge N+1.
- Frame duration is len × HOLD cycles. Example: LOGIN with HOLD = 1 occupies 13 cycles.
- `frame_done` is high in the first cycle `key` returns to K.
  - Without the macro, that is also the first IDLE cycle, so a new command can be accepted then.
  - Minimum spacing between frames is therefore 1 K cycle, or 1 + GAP_CYCLES K cycles with the macro.
- `cmd_valid` while busy is not an error. It waits for `cmd_ready`.

## Configuration
- `KEYPAD_TX_GAP_EN` defined: GAP state is present, and each frame is followed by GAP_CYCLES extra K cycles before `cmd_ready` rises.
- Undefined: GAP state and its counter are not built, and SEND goes straight to IDLE.

## Structure
- Shared package `keypad_pkg` holds:
  - code constants (PAD_0..PAD_9, PAD_S, PAD_M, PAD_K),
  - the `cmd_op` enum,
  - per-op frame lengths,
  - the FSM state typedef.
- Sub-module `keypad_frame_rom`: combinational, maps (op, index, id, pw) to (symbol, last).
- The top holds the FSM, hold counter, gap counter and registered outputs.

## Test plan
- LOGIN, id 001, pw 1111, HOLD = 1 → `key` = A,0,0,1,A,B,A,1,1,1,1,A,B on consecutive cycles, then K with `frame_done` = 1.
- ADD_USER, id 004, pw 1202, followed immediately by SELECT_USER, id 004 → 11-symbol frame, one K cycle, then S,0,0,4,B,B. Check `cmd_ready` timing.
- REMOVE_USER, id 001, HOLD = 3 → each of S,0,0,1,S,M is held 3 cycles (18 total), and `cmd_ready` stays low throughout.
- LOGIN with pw digit 4'b1100 → `cmd_err` pulse, `key` stays K, no `frame_done`, `cmd_ready` stays 1.
- Assert `rst` for one cycle at index 5 of LOGIN → next cycle `key` = K, `key_valid` = 0, no `frame_done`; a new command is accepted afterwards.
- With `KEYPAD_TX_GAP_EN` and GAP_CYCLES = 2 → 3 K cycles between back-to-back frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad protocol definitions: symbol codes, command ops, frame lengths,
// transmitter FSM states and the BCD digit check used on command acceptance.
package keypad_pkg;

    localparam logic [3:0] PAD_0 = 4'b0000;
    localparam logic [3:0] PAD_1 = 4'b0001;
    localparam logic [3:0] PAD_2 = 4'b0010;
    localparam logic [3:0] PAD_3 = 4'b0011;
    localparam logic [3:0] PAD_4 = 4'b0100;
    localparam logic [3:0] PAD_5 = 4'b0101;
    localparam logic [3:0] PAD_6 = 4'b0110;
    localparam logic [3:0] PAD_7 = 4'b0111;
    localparam logic [3:0] PAD_8 = 4'b1000;
    localparam logic [3:0] PAD_9 = 4'b1001;
    localparam logic [3:0] PAD_S = 4'b1010;
    localparam logic [3:0] PAD_M = 4'b1011;
    localparam logic [3:0] PAD_K = 4'b1111;

    typedef enum logic [1:0] {
        OP_LOGIN       = 2'd0,
        OP_ADD_USER    = 2'd1,
        OP_SELECT_USER = 2'd2,
        OP_REMOVE_USER = 2'd3
    } cmd_op_t;

    localparam logic [3:0] LEN_LOGIN  = 4'd13;
    localparam logic [3:0] LEN_ADD    = 4'd11;
    localparam logic [3:0] LEN_SELECT = 4'd6;
    localparam logic [3:0] LEN_REMOVE = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [3:0] frame_len(input cmd_op_t op);
        case (op)
            OP_LOGIN:    frame_len = LEN_LOGIN;
            OP_ADD_USER: frame_len = LEN_ADD;
            OP_SELECT_USER: frame_len = LEN_SELECT;
            default:     frame_len = LEN_REMOVE;
        endcase
    endfunction

    // Password digits only matter for ops whose frame carries them.
    function automatic logic digits_ok(input cmd_op_t op, input logic [11:0] id,
                                       input logic [15:0] pw);
        logic ok;
        ok = (id[11:8] <= PAD_9) && (id[7:4] <= PAD_9) && (id[3:0] <= PAD_9);
        if (op == OP_LOGIN || op == OP_ADD_USER) begin
            ok = ok && (pw[15:12] <= PAD_9) && (pw[11:8] <= PAD_9) &&
                 (pw[7:4] <= PAD_9) && (pw[3:0] <= PAD_9);
        end
        digits_ok = ok;
    endfunction

endpackage

// File: rtl/keypad_frame_rom.sv
// Combinational frame table: symbol at position idx of the frame for op,
// plus a flag marking the final symbol of that frame.
module keypad_frame_rom
    import keypad_pkg::*;
(
    input  cmd_op_t     op,
    input  logic [3:0]  idx,
    input  logic [11:0] id,
    input  logic [15:0] pw,
    output logic [3:0]  symbol,
    output logic        last
);

    always_comb begin
        symbol = PAD_K;
        case (op)
            OP_LOGIN: begin
                case (idx)
                    4'd0, 4'd4, 4'd6, 4'd11: symbol = PAD_S;
                    4'd1:  symbol = id[11:8];
                    4'd2:  symbol = id[7:4];
                    4'd3:  symbol = id[3:0];
                    4'd5, 4'd12: symbol = PAD_M;
                    4'd7:  symbol = pw[15:12];
                    4'd8:  symbol = pw[11:8];
                    4'd9:  symbol = pw[7:4];
                    4'd10: symbol = pw[3:0];
                    default: symbol = PAD_K;
                endcase
            end
            OP_ADD_USER: begin
                case (idx)
                    4'd0, 4'd9: symbol = PAD_S;
                    4'd1: symbol = id[11:8];
                    4'd2: symbol = id[7:4];
                    4'd3: symbol = id[3:0];
                    4'd4, 4'd10: symbol = PAD_M;
                    4'd5: symbol = pw[15:12];
                    4'd6: symbol = pw[11:8];
                    4'd7: symbol = pw[7:4];
                    4'd8: symbol = pw[3:0];
                    default: symbol = PAD_K;
                endcase
            end
            default: begin
                // SELECT ends M M, REMOVE ends S M; both share the id prefix.
                case (idx)
                    4'd0: symbol = PAD_S;
                    4'd1: symbol = id[11:8];
                    4'd2: symbol = id[7:4];
                    4'd3: symbol = id[3:0];
                    4'd4: symbol = (op == OP_SELECT_USER) ? PAD_M : PAD_S;
                    4'd5: symbol = PAD_M;
                    default: symbol = PAD_K;
                endcase
            end
        endcase
    end

    assign last = (idx == 4'(frame_len(op) - 4'd1));

endmodule

// File: rtl/keypad_frame_tx.sv
// Keypad frame transmitter: serialises one accepted command into keypad codes.
// Optional post-frame idle gap is built when KEYPAD_TX_GAP_EN is defined.
module keypad_frame_tx
    import keypad_pkg::*;
#(
    parameter int HOLD       = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [11:0] cmd_id,
    input  logic [15:0] cmd_pw,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        frame_done,
    output logic        cmd_err
);

    if ((HOLD < 1) || (HOLD > 15) || (GAP_CYCLES < 1) || (GAP_CYCLES > 256)) begin : g_bad_param
        $error("keypad_frame_tx: HOLD must be 1..15 and GAP_CYCLES 1..256");
    end

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t      state, state_d;
    cmd_op_t     op_q, op_d;
    logic [11:0] id_q, id_d;
    logic [15:0] pw_q, pw_d;
    logic [3:0]  idx_q, idx_d, hold_q, hold_d;
    logic        last_q, last_d;
    logic [3:0]  key_d;
    logic        key_valid_d, frame_done_d, cmd_err_d;
    logic [3:0]  rom_sym;
    logic        rom_last;
    logic        accept;
`ifdef KEYPAD_TX_GAP_EN
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    logic [7:0]  gap_q, gap_d;
`endif

    assign cmd_ready = (state == ST_IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;

    // The ROM looks one symbol ahead so key can be loaded as a register.
    keypad_frame_rom u_rom (
        .op     (op_q),
        .idx    (idx_q + 4'd1),
        .id     (id_q),
        .pw     (pw_q),
        .symbol (rom_sym),
        .last   (rom_last)
    );

    always_comb begin
        state_d      = state;
        op_d         = op_q;
        id_d         = id_q;
        pw_d         = pw_q;
        idx_d        = idx_q;
        hold_d       = hold_q;
        last_d       = last_q;
        key_d        = key;
        key_valid_d  = key_valid;
        frame_done_d = 1'b0;
        cmd_err_d    = 1'b0;
`ifdef KEYPAD_TX_GAP_EN
        gap_d        = gap_q;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (digits_ok(cmd_op_t'(cmd_op), cmd_id, cmd_pw)) begin
                        op_d        = cmd_op_t'(cmd_op);
                        id_d        = cmd_id;
                        pw_d        = cmd_pw;
                        idx_d       = 4'd0;
                        hold_d      = 4'd0;
                        last_d      = 1'b0;
                        key_d       = PAD_S;
                        key_valid_d = 1'b1;
                        state_d     = ST_SEND;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = 4'd0;
                    if (last_q) begin
                        key_d        = PAD_K;
                        key_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
`ifdef KEYPAD_TX_GAP_EN
                        gap_d        = 8'd0;
                        state_d      = ST_GAP;
`else
                        state_d      = ST_IDLE;
`endif
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        key_d  = rom_sym;
                        last_d = rom_last;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
`ifdef KEYPAD_TX_GAP_EN
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 8'd1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_LOGIN;
            id_q       <= '0;
            pw_q       <= '0;
            idx_q      <= '0;
            hold_q     <= '0;
            last_q     <= 1'b0;
            key        <= PAD_K;
            key_valid  <= 1'b0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
`ifdef KEYPAD_TX_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state      <= state_d;
            op_q       <= op_d;
            id_q       <= id_d;
            pw_q       <= pw_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            key        <= key_d;
            key_valid  <= key_valid_d;
            frame_done <= frame_done_d;
            cmd_err    <= cmd_err_d;
`ifdef KEYPAD_TX_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_frame_tx.sv
// Bench for keypad_frame_tx: two instances (HOLD=1 and HOLD=3) driven by
// directed and random commands, checked against a frame-table model.
module tb_keypad_frame_tx;

  localparam logic [3:0] C_S = 4'hA;
  localparam logic [3:0] C_M = 4'hB;
  localparam logic [3:0] C_K = 4'hF;
  localparam int GAP = 2;
`ifdef KEYPAD_TX_GAP_EN
  localparam int KGAP = 1 + GAP;
`else
  localparam int KGAP = 1;
`endif

  logic clk, rst;
  logic a_valid, a_ready, a_kv, a_fd, a_err;
  logic [1:0] a_op;
  logic [11:0] a_id;
  logic [15:0] a_pw;
  logic [3:0] a_key;
  logic b_valid, b_ready, b_kv, b_fd, b_err;
  logic [1:0] b_op;
  logic [11:0] b_id;
  logic [15:0] b_pw;
  logic [3:0] b_key;

  bit sel;
  logic [3:0] o_key;
  logic o_kv, o_fd, o_err, o_ready;
  logic [3:0] exp_q[$];
  int total, bad, cyc, done_cyc;
  bit b2b;

  keypad_frame_tx #(.HOLD(1), .GAP_CYCLES(GAP)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(a_op), .cmd_id(a_id), .cmd_pw(a_pw), .key(a_key),
    .key_valid(a_kv), .frame_done(a_fd), .cmd_err(a_err));

  keypad_frame_tx #(.HOLD(3), .GAP_CYCLES(GAP)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_id(b_id), .cmd_pw(b_pw), .key(b_key),
    .key_valid(b_kv), .frame_done(b_fd), .cmd_err(b_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    o_key   = sel ? b_key   : a_key;
    o_kv    = sel ? b_kv    : a_kv;
    o_fd    = sel ? b_fd    : a_fd;
    o_err   = sel ? b_err   : a_err;
    o_ready = sel ? b_ready : a_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [11:0] id,
                       input logic [15:0] pw);
    if (sel) begin b_valid = v; b_op = op; b_id = id; b_pw = pw; end
    else     begin a_valid = v; a_op = op; a_id = id; a_pw = pw; end
  endtask

  task automatic scramble();
    drive(1'b0, 2'($urandom_range(0, 3)), 12'($urandom), 16'($urandom));
  endtask

  // Reference: expected symbol list straight from the protocol frame table.
  function automatic void build_frame(input logic [1:0] op, input logic [11:0] id,
                                      input logic [15:0] pw);
    logic [3:0] d2, d1, d0, p3, p2, p1, p0;
    {d2, d1, d0} = id;
    {p3, p2, p1, p0} = pw;
    case (op)
      2'd0: exp_q = '{C_S, d2, d1, d0, C_S, C_M, C_S, p3, p2, p1, p0, C_S, C_M};
      2'd1: exp_q = '{C_S, d2, d1, d0, C_M, p3, p2, p1, p0, C_S, C_M};
      2'd2: exp_q = '{C_S, d2, d1, d0, C_M, C_M};
      default: exp_q = '{C_S, d2, d1, d0, C_S, C_M};
    endcase
  endfunction

  function automatic bit bcd_ok(input logic [1:0] op, input logic [11:0] id,
                                input logic [15:0] pw);
    bit ok = 1'b1;
    for (int i = 0; i < 3; i++) if (id[4*i +: 4] > 4'd9) ok = 1'b0;
    if (op < 2'd2) for (int i = 0; i < 4; i++) if (pw[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 64) begin @(negedge clk); n++; end
    chk("ready_wait", o_ready, 1);
  endtask

  task automatic run_frame(input logic [1:0] op, input logic [11:0] id, input logic [15:0] pw,
                           input bit chain, input logic [1:0] nop, input logic [11:0] nid,
                           input logic [15:0] npw);
    int hold;
    hold = sel ? 3 : 1;
    build_frame(op, id, pw);
    drive(1'b1, op, id, pw);
    wait_ready();
    @(negedge clk);
    if (chain) drive(1'b1, nop, nid, npw);
    else scramble();
    if (!bcd_ok(op, id, pw)) begin
      chk("err_pulse", o_err, 1);
      chk("err_key", o_key, C_K);
      chk("err_kv", o_kv, 0);
      chk("err_ready", o_ready, 1);
      @(negedge clk);
      chk("err_clear", o_err, 0);
      chk("err_no_done", o_fd, 0);
      b2b = 1'b0;
      return;
    end
    if (b2b) chk("frame_spacing", 32'(cyc - done_cyc), KGAP);
    foreach (exp_q[i]) begin
      for (int h = 0; h < hold; h++) begin
        chk($sformatf("sym%0d", i), o_key, exp_q[i]);
        chk("kv_high", o_kv, 1);
        chk("ready_busy", o_ready, 0);
        chk("done_busy", o_fd, 0);
        chk("err_busy", o_err, 0);
        if (!chain) scramble();
        @(negedge clk);
      end
    end
    chk("end_key", o_key, C_K);
    chk("end_kv", o_kv, 0);
    chk("end_done", o_fd, 1);
    chk("end_ready", o_ready, (KGAP == 1) ? 1 : 0);
    if (!chain) drive(1'b0, op, id, pw);
    done_cyc = cyc;
    b2b = chain;
  endtask

  initial begin
    logic [3:0] dig[7];
    logic [1:0] rop;
    total = 0; bad = 0; b2b = 1'b0; done_cyc = 0; sel = 1'b0;
    rst = 1'b1;
    a_valid = 0; a_op = 0; a_id = 0; a_pw = 0;
    b_valid = 0; b_op = 0; b_id = 0; b_pw = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_a_key", a_key, C_K);
    chk("rst_a_kv", a_kv, 0);
    chk("rst_a_done", a_fd, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_key", b_key, C_K);
    chk("rst_b_kv", b_kv, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", a_ready, 1);

    run_frame(2'd0, 12'h001, 16'h1111, 1'b0, 2'd0, 12'h0, 16'h0);
    @(negedge clk);
    run_frame(2'd1, 12'h004, 16'h1202, 1'b1, 2'd2, 12'h004, 16'hFFFF);
    run_frame(2'd2, 12'h004, 16'hFFFF, 1'b0, 2'd0, 12'h0, 16'h0);

    run_frame(2'd0, 12'h123, 16'h11C1, 1'b0, 2'd0, 12'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("err_idle_key", a_key, C_K);
      chk("err_idle_done", a_fd, 0);
      @(negedge clk);
    end

    // Reset while index 5 of a LOGIN frame is on the bus.
    build_frame(2'd0, 12'h789, 16'h4321);
    drive(1'b1, 2'd0, 12'h789, 16'h4321);
    wait_ready();
    @(negedge clk);
    drive(1'b0, 2'd0, 12'h789, 16'h4321);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("abort_at_idx5", a_key, exp_q[5]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_key", a_key, C_K);
    chk("abort_kv", a_kv, 0);
    chk("abort_done", a_fd, 0);
    chk("abort_ready_in_rst", a_ready, 0);
    @(negedge clk);
    chk("abort_no_done", a_fd, 0);
    chk("abort_ready", a_ready, 1);
    run_frame(2'd3, 12'h950, 16'h0, 1'b0, 2'd0, 12'h0, 16'h0);

    sel = 1'b1;
    @(negedge clk);
    run_frame(2'd3, 12'h001, 16'h0, 1'b0, 2'd0, 12'h0, 16'h0);
    run_frame(2'd1, 12'h321, 16'h9876, 1'b1, 2'd0, 12'h555, 16'h0123);
    run_frame(2'd0, 12'h555, 16'h0123, 1'b0, 2'd0, 12'h0, 16'h0);

    sel = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      for (int i = 0; i < 7; i++) dig[i] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) dig[$urandom_range(0, 6)] = 4'($urandom_range(10, 15));
      run_frame(rop, {dig[0], dig[1], dig[2]}, {dig[3], dig[4], dig[5], dig[6]},
                1'b0, 2'd0, 12'h0, 16'h0);
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) @(negedge clk);
    end
    run_frame(2'd3, 12'h246, 16'h0, 1'b1, 2'd0, 12'h135, 16'h7979);
    run_frame(2'd0, 12'h135, 16'h7979, 1'b0, 2'd0, 12'h0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
